sync_fifo: RTL
==============

# sync_fifo

Single-clock FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock, so no Gray-code pointer crossing is needed. It is generalised with a selectable read mode (registered-read or first-word-fall-through), programmable almost-full and almost-empty levels, and fill counts on both sides. It also keeps sticky overflow and underflow error flags. It sits between DSP stages and the capture and DMA logic inside a single clock domain.

## Interface
- ADDR_WIDTH, 12: log2 of the depth; DEPTH = 2^ADDR_WIDTH, all DEPTH entries usable.
- DATA_WIDTH, 64: word width.
- FWFT, 0: 0 = registered read (rddata updates on the popping edge); 1 = first-word-fall-through.
- AFULL_MARGIN, 10: wr_almostfull when count >= DEPTH-AFULL_MARGIN.
- AEMPTY_LEVEL, 2: rd_almostempty when rd_count <= AEMPTY_LEVEL.
- clk  in  1  single clock; everything is on the rising edge.
- srst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- wrreq  in  1  write request.
- wrdata  in  DATA_WIDTH  write data.
- wrfull  out  1  no free entry.
- wr_almostfull  out  1  threshold flag.
- wr_avail  out  ADDR_WIDTH+1  free entries.
- rdreq  in  1  read/pop request.
- rddata  out  DATA_WIDTH  read data.
- rdempty  out  1  nothing readable.
- rd_almostempty  out  1  threshold flag.
- rd_count  out  ADDR_WIDTH+1  readable words.
- clr_err  in  1  clears the sticky error flags.
- overflow  out  1  sticky: set by wrreq while wrfull.
- underflow  out  1  sticky: set by rdreq while rdempty.

## Operation
- **Accept rules:** write_allow = wrreq & ~wrfull; read_allow = rdreq & ~rdempty. Both use the registered flags.
- **Pointers:** wr_addr and rd_addr are ADDR_WIDTH+1 bits; the RAM index is the low ADDR_WIDTH bits, and the MSB handles wrap.
- **Occupancy count:** count (0..DEPTH) is registered; count_next = count + write_allow - read_allow.
- **Write-side outputs:** wrfull, wr_avail (= DEPTH - count) and wr_almostfull are all registered from count_next.
- **Readability:** a written word becomes readable one cycle after its accepting edge, covering the RAM read latency.
  - rd_count counts readable words and lags count by that one cycle for writes only.
  - In FWFT mode, rd_count includes the word held in the output register.
- **Mode 0:** rddata loads the head word at the edge where read_allow=1 and holds otherwise. The RAM address is looked ahead (rd_addr+1 when read_allow) so back-to-back pops run at full rate.
- **Mode 1:** rddata always shows the head word while rdempty=0, and read_allow pops it.
  - If another word is readable, it appears on the next edge with no bubble.
  - Otherwise rdempty rises on that edge.
- **Simultaneous read and write:**
  - When full, the write is refused and the read proceeds, so count drops by 1.
  - When empty, the read is refused and the write proceeds.
  - Otherwise count is unchanged and order is preserved.
- **Error flags:** overflow and underflow stay set until clr_err or srst. A set event in the same cycle as clr_err wins.
- **Reset values and srst:** srst discards all contents. Requests during srst are ignored and not flagged. Reset values:
  - pointers and count: 0
  - wrfull=0, wr_almostfull=0, wr_avail=DEPTH
  - rdempty=1, rd_almostempty=1, rd_count=0
  - rddata=0
  - overflow=0, underflow=0

## Timing
- Write accepted at edge k:
  - wr_avail and wrfull update after edge k.
  - Mode 0: rdempty falls and rd_count increments after edge k+1.
  - Mode 1: rddata is valid and rdempty falls after edge k+2.
- Mode 0 pop requested in the cycle before edge j: rddata is valid after edge j.
- Sustained throughput is one write and one read per cycle.
- The flag outputs (wrfull, rdempty, both almost flags, overflow, underflow) are registered; there are no combinational paths from inputs to them.

## Structure
- **Shared package fifo_pkg:** mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1, plus the default threshold constants. The afifo defaults move here too.
- **Sub-module scram_fifo:** single-clock simple-dual-port RAM.
  - Synchronous read with 1-cycle latency.
  - A read of an address being written in the same cycle returns the old data.
- **Control:** pointers, counts, flags and the FWFT prefetch stay in sync_fifo.

## Test plan
All scenarios use ADDR_WIDTH=3, DATA_WIDTH=8, AFULL_MARGIN=2, AEMPTY_LEVEL=1 unless noted.
- **Fill:** 9 back-to-back writes of 0x01..0x09 from reset. Required response:
  - wr_almostfull=1 from count 6.
  - wrfull=1 and wr_avail=0 after the 8th write.
  - 0x09 is dropped and overflow=1.
- **Drain, FWFT=0:** 9 rdreq on the full FIFO. Required response:
  - rddata returns 0x01..0x08 in order.
  - rdempty=1 after the 8th pop.
  - underflow=1; a following clr_err clears it.
- **First word, FWFT=1:** write 0xA5 at edge k. Required response:
  - rddata=0xA5 and rdempty=0 after edge k+2.
  - One pop makes rdempty=1 on the next edge.
- **Simultaneous access:**
  - Full FIFO with wrreq=rdreq=1: count becomes 7 and wrfull=0.
  - At count 4 with 10 cycles of wrreq=rdreq=1: count stays 4 and output order is intact.
- **Wrap, both modes:** 40 words with random wrreq/rdreq gaps. Required response:
  - Output equals input order across several pointer wraps.
  - rd_count matches the reference-model count every cycle.
- **srst mid-operation:** srst at count 5 with wrreq=rdreq=1 asserted. Required response after the edge:
  - count=0, rdempty=1, wr_avail=8, rddata=0.
  - No error flag is set.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: constants shared by the single-clock and dual-clock FIFOs.
//   FIFO_MODE_*        read-mode selectors for the FWFT parameter
//   FIFO_*_DEF         default geometry and threshold settings
package fifo_pkg;

   // Read modes
   localparam int unsigned FIFO_MODE_STD  = 0;  // registered read
   localparam int unsigned FIFO_MODE_FWFT = 1;  // first-word-fall-through

   // Default geometry and thresholds
   localparam int unsigned FIFO_ADDR_WIDTH_DEF   = 12;
   localparam int unsigned FIFO_DATA_WIDTH_DEF   = 64;
   localparam int unsigned FIFO_AFULL_MARGIN_DEF = 10;
   localparam int unsigned FIFO_AEMPTY_LEVEL_DEF = 2;

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake bundle of a single-clock FIFO.
//   write side : wrreq, wrdata -> wrfull, wr_almostfull, wr_avail
//   read side  : rdreq         -> rddata, rdempty, rd_almostempty, rd_count
//   errors     : clr_err       -> overflow, underflow (sticky)
// master = producer/consumer logic, slave = the FIFO.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH_DEF
) ();

   logic                  wrreq;
   logic [DATA_WIDTH-1:0] wrdata;
   logic                  wrfull;
   logic                  wr_almostfull;
   logic [ADDR_WIDTH:0]   wr_avail;

   logic                  rdreq;
   logic [DATA_WIDTH-1:0] rddata;
   logic                  rdempty;
   logic                  rd_almostempty;
   logic [ADDR_WIDTH:0]   rd_count;

   logic                  clr_err;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wrreq, wrdata, rdreq, clr_err,
      input  wrfull, wr_almostfull, wr_avail,
      input  rddata, rdempty, rd_almostempty, rd_count,
      input  overflow, underflow
   );

   modport slave (
      input  wrreq, wrdata, rdreq, clr_err,
      output wrfull, wr_almostfull, wr_avail,
      output rddata, rdempty, rd_almostempty, rd_count,
      output overflow, underflow
   );

endinterface

// File: rtl/scram_fifo.sv
// scram_fifo: single-clock simple-dual-port RAM.
//   clk          clock
//   we/waddr/wdata  write port
//   raddr/rdata  synchronous read port, one cycle latency
// A read of the address written in the same cycle returns the old word.
module scram_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered-read or FWFT output,
// programmable almost flags, fill counts and sticky error flags.
//   clk   clock, rising edge
//   srst  synchronous active-high reset, discards contents
//   bus   sync_fifo_if slave: write side, read side, error flags
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH   = FIFO_DATA_WIDTH_DEF,
   parameter int unsigned FWFT         = FIFO_MODE_STD,
   parameter int unsigned AFULL_MARGIN = FIFO_AFULL_MARGIN_DEF,
   parameter int unsigned AEMPTY_LEVEL = FIFO_AEMPTY_LEVEL_DEF
) (
   input logic        clk,
   input logic        srst,
   sync_fifo_if.slave bus
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   typedef logic [ADDR_WIDTH:0]   ptr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   localparam ptr_t DepthP  = ptr_t'(Depth);
   localparam ptr_t AfullP  = ptr_t'(Depth - AFULL_MARGIN);
   localparam ptr_t AemptyP = ptr_t'(AEMPTY_LEVEL);
   localparam bit   IsFwft  = (FWFT == FIFO_MODE_FWFT);

   ptr_t  wr_addr_q, wr_addr_d;
   ptr_t  rd_addr_q, rd_addr_d;
   ptr_t  count_q, count_d;
   logic  wr_pend_q;
   logic  out_valid_q, out_valid_d;
   logic  wrfull_q, wrfull_d;
   logic  wr_almostfull_q, wr_almostfull_d;
   ptr_t  wr_avail_q, wr_avail_d;
   logic  rdempty_q, rdempty_d;
   logic  rd_almostempty_q, rd_almostempty_d;
   ptr_t  rd_count_q, rd_count_d;
   data_t rddata_q, rddata_d;
   logic  overflow_q, overflow_d;
   logic  underflow_q, underflow_d;

   logic  write_allow;
   logic  read_allow;
   logic  ram_pop;
   logic  ram_we;
   ptr_t  ram_ready;
   ptr_t  rd_base;
   data_t ram_rdata;

   always_comb begin
      write_allow = bus.wrreq & ~wrfull_q;
      read_allow  = bus.rdreq & ~rdempty_q;
      ram_we      = write_allow & ~srst;

      // Words whose RAM read data is already valid: written before the last edge
      // and not yet moved to the output register.
      ram_ready = (wr_addr_q - rd_addr_q) - ptr_t'(wr_pend_q);

      // FWFT prefetches into an empty output register, or refills it on a pop.
      if (IsFwft) begin
         ram_pop = (ram_ready != '0) & (~out_valid_q | read_allow);
      end else begin
         ram_pop = read_allow;
      end

      wr_addr_d = wr_addr_q + ptr_t'(write_allow);
      // Look-ahead: the RAM is addressed with the post-pop pointer so the next
      // head word is on ram_rdata one edge later.
      rd_addr_d = rd_addr_q + ptr_t'(ram_pop);
      count_d   = count_q + ptr_t'(write_allow) - ptr_t'(read_allow);

      wrfull_d        = (count_d == DepthP);
      wr_avail_d      = DepthP - count_d;
      wr_almostfull_d = (count_d >= AfullP);

      out_valid_d = IsFwft & (ram_pop | (out_valid_q & ~read_allow));

      // Writes from this edge are not readable until the next one.
      rd_base = count_d - ptr_t'(write_allow);
      if (IsFwft && !out_valid_d) begin
         rd_count_d = '0;
      end else begin
         rd_count_d = rd_base;
      end
      rdempty_d        = (rd_count_d == '0);
      rd_almostempty_d = (rd_count_d <= AemptyP);

      rddata_d = ram_pop ? ram_rdata : rddata_q;

      // A set event beats clr_err in the same cycle.
      overflow_d  = overflow_q & ~bus.clr_err;
      underflow_d = underflow_q & ~bus.clr_err;
      if (bus.wrreq && wrfull_q) begin
         overflow_d = 1'b1;
      end
      if (bus.rdreq && rdempty_q) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_addr_q        <= '0;
         rd_addr_q        <= '0;
         count_q          <= '0;
         wr_pend_q        <= 1'b0;
         out_valid_q      <= 1'b0;
         wrfull_q         <= 1'b0;
         wr_almostfull_q  <= 1'b0;
         wr_avail_q       <= DepthP;
         rdempty_q        <= 1'b1;
         rd_almostempty_q <= 1'b1;
         rd_count_q       <= '0;
         rddata_q         <= '0;
         overflow_q       <= 1'b0;
         underflow_q      <= 1'b0;
      end else begin
         wr_addr_q        <= wr_addr_d;
         rd_addr_q        <= rd_addr_d;
         count_q          <= count_d;
         wr_pend_q        <= write_allow;
         out_valid_q      <= out_valid_d;
         wrfull_q         <= wrfull_d;
         wr_almostfull_q  <= wr_almostfull_d;
         wr_avail_q       <= wr_avail_d;
         rdempty_q        <= rdempty_d;
         rd_almostempty_q <= rd_almostempty_d;
         rd_count_q       <= rd_count_d;
         rddata_q         <= rddata_d;
         overflow_q       <= overflow_d;
         underflow_q      <= underflow_d;
      end
   end

   scram_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr_q[ADDR_WIDTH-1:0]),
      .wdata (bus.wrdata),
      .raddr (rd_addr_d[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   assign bus.wrfull         = wrfull_q;
   assign bus.wr_almostfull  = wr_almostfull_q;
   assign bus.wr_avail       = wr_avail_q;
   assign bus.rddata         = rddata_q;
   assign bus.rdempty        = rdempty_q;
   assign bus.rd_almostempty = rd_almostempty_q;
   assign bus.rd_count       = rd_count_q;
   assign bus.overflow       = overflow_q;
   assign bus.underflow      = underflow_q;

endmodule
